// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module  : hazard_forward_unit
// Purpose : EX/MEM/WB shadow scoreboard that drives the EX forwarding selects,
//           the load-use stall controls and a taken-branch flush sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_forward_unit #(
  parameter int FLUSH_CYCLES = 1,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [2:0]  id_dest,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        ex_branch_taken,
  output logic [1:0]  saidaAfw,
  output logic [1:0]  saidaBfw,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        flush,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       usesRs;
    logic       usesRt;
    logic [2:0] dest;
    logic       regWrite;
    logic       memRead;
  } slot_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [2:0] c_flushReload = 3'(FLUSH_CYCLES - 1);
  localparam logic [1:0] c_selBank     = 2'b00;
  localparam logic [1:0] c_selMem      = 2'b10;
  localparam logic [1:0] c_selWb       = 2'b01;

  slot_t       r_exSlot;
  slot_t       r_memSlot;
  slot_t       r_wbSlot;
  slot_t       w_idSlot;
  state_t      r_state;
  state_t      w_nextState;
  logic [2:0]  r_cnt;
  logic [2:0]  w_nextCnt;
  logic [15:0] r_stallCount;
  logic        w_loadUse;
  logic        w_stallApplied;

  function automatic logic slotMatch(input slot_t s, input logic [2:0] r);
    return s.valid && s.regWrite && (s.dest == r) && !(R0_HARDWIRED && (r == 3'd0));
  endfunction

  // MEM holds the younger result, so it wins over WB for the same register.
  function automatic logic [1:0] fwdSel(input logic uses, input logic [2:0] r,
                                        input slot_t mem, input slot_t wb);
    if (uses && slotMatch(mem, r))
      return c_selMem;
    else if (uses && slotMatch(wb, r))
      return c_selWb;
    else
      return c_selBank;
  endfunction

  always_comb begin
    w_idSlot          = '0;
    w_idSlot.valid    = 1'b1;
    w_idSlot.rs       = id_rs;
    w_idSlot.rt       = id_rt;
    w_idSlot.usesRs   = id_uses_rs;
    w_idSlot.usesRt   = id_uses_rt;
    w_idSlot.dest     = id_dest;
    w_idSlot.regWrite = id_regwrite;
    w_idSlot.memRead  = id_memread;
  end

  assign w_loadUse = id_valid && r_exSlot.memRead &&
                     ((id_uses_rs && slotMatch(r_exSlot, id_rs)) ||
                      (id_uses_rt && slotMatch(r_exSlot, id_rt)));

  assign saidaAfw = fwdSel(r_exSlot.valid && r_exSlot.usesRs, r_exSlot.rs, r_memSlot, r_wbSlot);
  assign saidaBfw = fwdSel(r_exSlot.valid && r_exSlot.usesRt, r_exSlot.rt, r_memSlot, r_wbSlot);
  assign stall_count = r_stallCount;

  always_comb begin
    w_nextState    = r_state;
    w_nextCnt      = r_cnt;
    pc_write       = 1'b1;
    ifid_write     = 1'b1;
    idex_bubble    = 1'b0;
    flush          = 1'b0;
    w_stallApplied = 1'b0;
    // While reset is held every input is ignored and the controls sit idle.
    if (!reset) begin
      unique case (r_state)
        RUN: begin
          if (ex_branch_taken) begin
            flush       = 1'b1;
            idex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_nextState = FLUSH;
              w_nextCnt   = c_flushReload;
            end
          end else if (w_loadUse) begin
            pc_write       = 1'b0;
            ifid_write     = 1'b0;
            idex_bubble    = 1'b1;
            w_stallApplied = 1'b1;
          end
        end
        FLUSH: begin
          flush       = 1'b1;
          idex_bubble = 1'b1;
          w_nextCnt   = r_cnt - 3'd1;
          if (r_cnt == 3'd1)
            w_nextState = RUN;
        end
        default: w_nextState = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_exSlot     <= '0;
      r_memSlot    <= '0;
      r_wbSlot     <= '0;
      r_state      <= RUN;
      r_cnt        <= '0;
      r_stallCount <= '0;
    end else begin
      r_wbSlot  <= r_memSlot;
      r_memSlot <= r_exSlot;
      if (idex_bubble || !id_valid)
        r_exSlot <= '0;
      else
        r_exSlot <= w_idSlot;
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (w_stallApplied && (r_stallCount != 16'hFFFF))
        r_stallCount <= r_stallCount + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// Bench for hazard_forward_unit: directed table on a 1-cycle-flush instance,
// hand sequences on a 3-cycle-flush instance, random traffic vs. a pipeline model.
module tb_hazard_forward_unit;

  logic        clock;
  logic        reset;
  logic        id_valid;
  logic [2:0]  id_rs;
  logic [2:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic [2:0]  id_dest;
  logic        id_regwrite;
  logic        id_memread;
  logic        ex_branch_taken;

  logic [1:0]  selA [2];
  logic [1:0]  selB [2];
  logic        pcW  [2];
  logic        ifW  [2];
  logic        bub  [2];
  logic        fl   [2];
  logic [15:0] sc   [2];

  int checks   = 0;
  int failures = 0;

  hazard_forward_unit #(.FLUSH_CYCLES(1), .R0_HARDWIRED(1'b1)) dut1 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_branch_taken(ex_branch_taken),
    .saidaAfw(selA[0]), .saidaBfw(selB[0]), .pc_write(pcW[0]), .ifid_write(ifW[0]),
    .idex_bubble(bub[0]), .flush(fl[0]), .stall_count(sc[0])
  );

  hazard_forward_unit #(.FLUSH_CYCLES(3), .R0_HARDWIRED(1'b1)) dut3 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_branch_taken(ex_branch_taken),
    .saidaAfw(selA[1]), .saidaBfw(selB[1]), .pc_write(pcW[1]), .ifid_write(ifW[1]),
    .idex_bubble(bub[1]), .flush(fl[1]), .stall_count(sc[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit       rst;
    bit       v;
    bit [2:0] rs;
    bit [2:0] rt;
    bit       urs;
    bit       urt;
    bit [2:0] d;
    bit       rw;
    bit       mr;
    bit       br;
  } in_t;

  typedef struct {
    in_t      i;
    bit [1:0] a;
    bit [1:0] b;
    bit       pc;
    bit       ifw;
    bit       bub;
    bit       fl;
    int       sc;
  } vec_t;

  // Reference model: instructions in flight, remaining flush cycles, stall tally.
  in_t pipe [2][3];
  int  flushLeft [2];
  int  stalls [2];
  int  flushLen [2] = '{1, 3};

  function automatic in_t mk(bit v, bit [2:0] rs, bit [2:0] rt, bit urs, bit urt,
                             bit [2:0] d, bit rw, bit mr, bit br);
    in_t x;
    x.rst = 1'b0; x.v = v; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt;
    x.d = d; x.rw = rw; x.mr = mr; x.br = br;
    return x;
  endfunction

  function automatic vec_t mkv(in_t i, bit [1:0] a, bit [1:0] b, bit pc, bit ifw,
                               bit bb, bit f, int s);
    vec_t t;
    t.i = i; t.a = a; t.b = b; t.pc = pc; t.ifw = ifw; t.bub = bb; t.fl = f; t.sc = s;
    return t;
  endfunction

  function automatic bit hit(in_t s, bit [2:0] r);
    return s.v && s.rw && (s.d == r) && (r != 3'd0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic modelStep(input int k, input in_t x, input string tag);
    in_t ex, mem, wb, blank;
    int eA, eB;
    bit ePc, eIf, eBub, eFl, stall, loadUse;
    blank = '{default: 0};
    ex = pipe[k][0]; mem = pipe[k][1]; wb = pipe[k][2];
    eA = !ex.v ? 0 : (ex.urs && hit(mem, ex.rs)) ? 2 : (ex.urs && hit(wb, ex.rs)) ? 1 : 0;
    eB = !ex.v ? 0 : (ex.urt && hit(mem, ex.rt)) ? 2 : (ex.urt && hit(wb, ex.rt)) ? 1 : 0;
    loadUse = x.v && ex.v && ex.mr && ((x.urs && hit(ex, x.rs)) || (x.urt && hit(ex, x.rt)));
    ePc = 1; eIf = 1; eBub = 0; eFl = 0; stall = 0;
    if (!x.rst) begin
      if (flushLeft[k] > 0 || x.br) begin
        eFl = 1; eBub = 1;
      end else if (loadUse) begin
        ePc = 0; eIf = 0; eBub = 1; stall = 1;
      end
    end
    chk($sformatf("%s[%0d].selA", tag, k), 32'(selA[k]), 32'(eA));
    chk($sformatf("%s[%0d].selB", tag, k), 32'(selB[k]), 32'(eB));
    chk($sformatf("%s[%0d].pc_write", tag, k), 32'(pcW[k]), 32'(ePc));
    chk($sformatf("%s[%0d].ifid_write", tag, k), 32'(ifW[k]), 32'(eIf));
    chk($sformatf("%s[%0d].bubble", tag, k), 32'(bub[k]), 32'(eBub));
    chk($sformatf("%s[%0d].flush", tag, k), 32'(fl[k]), 32'(eFl));
    chk($sformatf("%s[%0d].stall_count", tag, k), 32'(sc[k]), 32'(stalls[k]));
    if (x.rst) begin
      for (int j = 0; j < 3; j++) pipe[k][j] = blank;
      flushLeft[k] = 0;
      stalls[k] = 0;
    end else begin
      pipe[k][2] = mem;
      pipe[k][1] = ex;
      pipe[k][0] = (eBub || !x.v) ? blank : x;
      if (flushLeft[k] > 0) flushLeft[k]--;
      else if (x.br) flushLeft[k] = flushLen[k] - 1;
      if (stall && stalls[k] < 65535) stalls[k]++;
    end
  endtask

  task automatic drive(input in_t x);
    reset = x.rst; id_valid = x.v; id_rs = x.rs; id_rt = x.rt;
    id_uses_rs = x.urs; id_uses_rt = x.urt; id_dest = x.d;
    id_regwrite = x.rw; id_memread = x.mr; ex_branch_taken = x.br;
  endtask

  // Drive a cycle's inputs and, at the falling edge, check both instances against the model.
  task automatic runCycle(input in_t x, input string tag);
    drive(x);
    @(negedge clock);
    modelStep(0, x, tag);
    modelStep(1, x, tag);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  vec_t tbl [23];
  in_t  rstIn, nopIn, brIn, x;

  initial begin
    nopIn = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rstIn = nopIn; rstIn.rst = 1'b1;
    brIn  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    x = rstIn; x.br = 1'b1; x.v = 1'b1; x.d = 3'd3; x.rw = 1'b1;

    //                  inputs                                  A  B pc if bb fl sc
    tbl[0]  = mkv(rstIn,                                  0, 0, 1, 1, 0, 0, 0);
    tbl[1]  = mkv(x,                                      0, 0, 1, 1, 0, 0, 0);
    tbl[2]  = mkv(mk(1, 1, 2, 1, 1, 3, 1, 0, 0),          0, 0, 1, 1, 0, 0, 0);
    tbl[3]  = mkv(mk(1, 3, 1, 1, 1, 4, 1, 0, 0),          0, 0, 1, 1, 0, 0, 0);
    tbl[4]  = mkv(nopIn,                                  2, 0, 1, 1, 0, 0, 0);
    tbl[5]  = mkv(mk(1, 1, 2, 1, 1, 3, 1, 0, 0),          0, 0, 1, 1, 0, 0, 0);
    tbl[6]  = mkv(nopIn,                                  0, 0, 1, 1, 0, 0, 0);
    tbl[7]  = mkv(mk(1, 1, 3, 1, 1, 5, 1, 0, 0),          0, 0, 1, 1, 0, 0, 0);
    tbl[8]  = mkv(mk(1, 1, 2, 1, 1, 3, 1, 0, 0),          0, 1, 1, 1, 0, 0, 0);
    tbl[9]  = mkv(mk(1, 2, 1, 1, 1, 3, 1, 0, 0),          0, 0, 1, 1, 0, 0, 0);
    tbl[10] = mkv(mk(1, 3, 4, 1, 1, 6, 1, 0, 0),          0, 0, 1, 1, 0, 0, 0);
    tbl[11] = mkv(mk(1, 1, 0, 1, 0, 2, 1, 1, 0),          2, 0, 1, 1, 0, 0, 0);
    tbl[12] = mkv(mk(1, 2, 2, 1, 1, 6, 1, 0, 0),          0, 0, 0, 0, 1, 0, 0);
    tbl[13] = mkv(mk(1, 2, 2, 1, 1, 6, 1, 0, 0),          0, 0, 1, 1, 0, 0, 1);
    tbl[14] = mkv(nopIn,                                  1, 1, 1, 1, 0, 0, 1);
    tbl[15] = mkv(mk(1, 6, 6, 1, 1, 7, 1, 0, 1),          0, 0, 1, 1, 1, 1, 1);
    tbl[16] = mkv(mk(1, 6, 6, 1, 1, 7, 1, 0, 0),          0, 0, 1, 1, 0, 0, 1);
    tbl[17] = mkv(mk(1, 0, 0, 0, 0, 4, 1, 1, 0),          0, 0, 1, 1, 0, 0, 1);
    tbl[18] = mkv(mk(1, 4, 0, 1, 0, 5, 1, 0, 1),          0, 0, 1, 1, 1, 1, 1);
    tbl[19] = mkv(mk(1, 1, 2, 1, 1, 0, 1, 1, 0),          0, 0, 1, 1, 0, 0, 1);
    tbl[20] = mkv(mk(1, 0, 0, 1, 1, 3, 1, 0, 0),          0, 0, 1, 1, 0, 0, 1);
    tbl[21] = mkv(nopIn,                                  0, 0, 1, 1, 0, 0, 1);
    tbl[22] = mkv(nopIn,                                  0, 0, 1, 1, 0, 0, 1);

    // Registers are unknown before the first reset edge, so this cycle is not checked.
    drive(rstIn);
    tick();

    for (int r = 0; r < 23; r++) begin
      runCycle(tbl[r].i, $sformatf("row%0d", r));
      chk($sformatf("tbl%0d.selA", r), 32'(selA[0]), 32'(tbl[r].a));
      chk($sformatf("tbl%0d.selB", r), 32'(selB[0]), 32'(tbl[r].b));
      chk($sformatf("tbl%0d.pc_write", r), 32'(pcW[0]), 32'(tbl[r].pc));
      chk($sformatf("tbl%0d.ifid_write", r), 32'(ifW[0]), 32'(tbl[r].ifw));
      chk($sformatf("tbl%0d.bubble", r), 32'(bub[0]), 32'(tbl[r].bub));
      chk($sformatf("tbl%0d.flush", r), 32'(fl[0]), 32'(tbl[r].fl));
      chk($sformatf("tbl%0d.stall_count", r), 32'(sc[0]), 32'(tbl[r].sc));
      tick();
    end

    // Three-cycle flush on dut3 versus single-cycle flush on dut1.
    runCycle(rstIn, "f3rst"); tick();
    runCycle(brIn, "f3c1");
    chk("f3c1.flush3", 32'(fl[1]), 32'd1);
    chk("f3c1.flush1", 32'(fl[0]), 32'd1);
    tick();
    runCycle(nopIn, "f3c2");
    chk("f3c2.flush3", 32'(fl[1]), 32'd1);
    chk("f3c2.flush1", 32'(fl[0]), 32'd0);
    tick();
    runCycle(nopIn, "f3c3");
    chk("f3c3.flush3", 32'(fl[1]), 32'd1);
    chk("f3c3.bubble3", 32'(bub[1]), 32'd1);
    tick();
    runCycle(nopIn, "f3c4");
    chk("f3c4.flush3", 32'(fl[1]), 32'd0);
    tick();

    // Build up a stall, then reset in the second cycle of a three-cycle flush.
    runCycle(mk(1, 1, 0, 1, 0, 2, 1, 1, 0), "mr_lw"); tick();
    runCycle(mk(1, 2, 2, 1, 1, 6, 1, 0, 0), "mr_use");
    chk("mr_use.pc_write3", 32'(pcW[1]), 32'd0);
    tick();
    runCycle(mk(1, 2, 2, 1, 1, 6, 1, 0, 1), "mr_br");
    chk("mr_br.flush3", 32'(fl[1]), 32'd1);
    chk("mr_br.stall_count3", 32'(sc[1]), 32'd1);
    tick();
    x = rstIn; x.br = 1'b1;
    runCycle(x, "mr_rst");
    chk("mr_rst.flush3", 32'(fl[1]), 32'd0);
    chk("mr_rst.pc_write3", 32'(pcW[1]), 32'd1);
    tick();
    runCycle(nopIn, "mr_after");
    chk("mr_after.flush3", 32'(fl[1]), 32'd0);
    chk("mr_after.pc_write3", 32'(pcW[1]), 32'd1);
    chk("mr_after.stall_count3", 32'(sc[1]), 32'd0);
    chk("mr_after.selA3", 32'(selA[1]), 32'd0);
    chk("mr_after.selB3", 32'(selB[1]), 32'd0);
    tick();

    // Random traffic on a small register range to provoke frequent hazards.
    for (int n = 0; n < 3000; n++) begin
      x.rst = ($urandom_range(0, 99) == 0);
      x.v   = ($urandom_range(0, 7) != 0);
      x.rs  = 3'($urandom_range(0, 3));
      x.rt  = 3'($urandom_range(0, 3));
      x.urs = 1'($urandom_range(0, 1));
      x.urt = 1'($urandom_range(0, 1));
      x.d   = 3'($urandom_range(0, 3));
      x.rw  = ($urandom_range(0, 3) != 0);
      x.mr  = ($urandom_range(0, 2) == 0);
      x.br  = ($urandom_range(0, 9) == 0);
      runCycle(x, "rnd");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
